pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, the generalised replacement for fixed F/D latches. Carries PC, instruction word, branch-delay flag and exception code from one stage to the next under a valid/ready handshake. Supports interrupt/exception flush to the kernel PC and bubble (null-slot) insertion. Optionally includes a one-entry skid buffer so that upstream ready does not depend combinationally on downstream ready.

## Interface
- DATA_W, 32, instruction word width
- PC_W, 32, PC width
- EXC_W, 5, exception code width; code 0 means no exception
- PC_DEFAULT, 32'h0000_3000, out_pc value after reset
- PC_KERNEL, 32'h0000_4180, out_pc value after flush

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  upstream PC
- in_instr  in  DATA_W  upstream instruction
- in_bd  in  1  upstream entry is in a delay slot
- in_exc  in  EXC_W  upstream exception code
- flush  in  1  interrupt/exception request; empties stage
- null_slot  in  1  squash the instruction of the next held entry
- out_valid  out  1  held entry present
- out_ready  in  1  downstream accepts
- out_pc, out_instr, out_bd, out_exc  out  PC_W/DATA_W/1/EXC_W  held entry fields
- occupancy  out  2  entries held (0..2; max 1 without skid)

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Capture rule: stored instr = (in_exc != 0) ? 0 : in_instr; pc, bd, exc stored unchanged. The first recorded exception travels with the entry; the faulting instruction word is never forwarded.
- Priority per edge: reset > flush > null_slot > normal.
- flush: both entries invalidated; out_valid=0, out_pc=PC_KERNEL, out_instr=0, out_bd=0, out_exc=0, occupancy=0. in_ready=0 that cycle; any presented input is dropped. The pop of the held entry in the same cycle is still reported (out_valid was 1), so downstream must treat flush as dominating.
- null_slot (flush low): in_ready=0 that cycle. Main entry next state is computed normally (held, promoted from skid, or emptied by pop) and its instr is then forced to 0. pc/bd/exc/valid are unaffected, so the slot keeps its PC for EPC reporting.
- Normal, no skid: main loads on push; empties on pop without push.
- Normal, with skid: push while main empty or popping goes to main; push while main full and not popping goes to skid. On pop with skid full, skid promotes to main. Order is strictly FIFO.
- Outputs hold their values while out_valid=1 and out_ready=0.
- Reset (low): out_pc=PC_DEFAULT, all other outputs 0 except in_ready, which is 1 once reset is released. Asynchronous assertion mid-transfer discards both entries.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is on the outputs after edge N.
- Throughput is 1 entry/cycle under continuous in_valid and out_ready.
- in_ready without skid: in_ready = (!out_valid | out_ready) & !flush & !null_slot. This is combinational from out_ready.
- in_ready with skid: in_ready = !skid_valid & !flush & !null_slot. There is no out_ready path; in_ready falls one cycle after the skid fills.
- occupancy is registered and updates on the same edge as the entries.

## Configuration
- PIPE_STAGE_SKID_EN defined: one-entry skid buffer is present; occupancy may read 2; in_ready is decoupled from out_ready.
- PIPE_STAGE_SKID_EN undefined: single register only; occupancy is never 2; in_ready follows out_ready combinationally. Reset, flush, null_slot and capture behaviour are otherwise identical.

## Test plan
- Reset, then push pc=0x3004, instr=0x2408_0001, exc=0 → out_valid=1, out_pc=0x3004, out_instr=0x2408_0001 after one edge.
- Push with in_exc=5'd4, instr=0x8C08_0000 → out_instr=0, out_exc=4, out_pc unchanged.
- Skid build: hold out_ready=0 and push two entries (0x3000, 0x3004) → occupancy=2, in_ready=0; raise out_ready → pops 0x3000 then 0x3004 in order.
- flush while occupancy=2 → next edge out_valid=0, out_pc=0x4180, out_instr=0, occupancy=0; input presented that cycle is lost.
- null_slot with main entry pc=0x3008, bd=1 → out_instr=0, out_pc=0x3008, out_bd=1, out_valid stays 1, in_ready=0 that cycle.
- Assert reset low mid-stream with skid full → outputs go immediately to out_pc=0x3000, out_valid=0, occupancy=0, without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-kernel and null-slot squash.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that decouples in_ready from out_ready.
module pipe_stage_reg #(
   parameter int              DATA_W     = 32,
   parameter int              PC_W       = 32,
   parameter int              EXC_W      = 5,
   parameter logic [PC_W-1:0] PC_DEFAULT = 32'h0000_3000,
   parameter logic [PC_W-1:0] PC_KERNEL  = 32'h0000_4180
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_instr,
   input  logic              in_bd,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic              flush,
   input  logic              null_slot,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_instr,
   output logic              out_bd,
   output logic [EXC_W-1:0]  out_exc,
   output logic [1:0]        occupancy
);

   // Entry layout: {pc, instr, bd, exc}
   localparam int E_W      = PC_W + DATA_W + 1 + EXC_W;
   localparam int INSTR_LO = EXC_W + 1;
   localparam int INSTR_HI = EXC_W + DATA_W;
   localparam int PC_LO    = EXC_W + DATA_W + 1;

   localparam logic [E_W-1:0] DEFAULT_ENTRY = {PC_DEFAULT, {(E_W-PC_W){1'b0}}};
   localparam logic [E_W-1:0] KERNEL_ENTRY  = {PC_KERNEL,  {(E_W-PC_W){1'b0}}};

   logic [E_W-1:0] main_reg, main_next, in_entry;
   logic           main_valid_reg, main_valid_next;
   logic [1:0]     occupancy_reg, occupancy_next;
   logic           push, pop;

   // A faulting instruction word is never forwarded; its exception code travels instead.
   assign in_entry = {in_pc, (in_exc != '0) ? {DATA_W{1'b0}} : in_instr, in_bd, in_exc};

   assign push = in_valid & in_ready;
   assign pop  = main_valid_reg & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic [E_W-1:0] skid_reg, skid_next;
   logic           skid_valid_reg, skid_valid_next;

   assign in_ready = reset & ~skid_valid_reg & ~flush & ~null_slot;

   always_comb begin
      main_next       = main_reg;
      main_valid_next = main_valid_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;
      if (flush) begin
         main_next       = KERNEL_ENTRY;
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else begin
         if (pop) begin
            if (skid_valid_reg) begin
               main_next       = skid_reg;
               main_valid_next = 1'b1;
               skid_valid_next = 1'b0;
            end else if (push) begin
               main_next       = in_entry;
               main_valid_next = 1'b1;
            end else begin
               main_valid_next = 1'b0;
            end
         end else if (push) begin
            if (!main_valid_reg) begin
               main_next       = in_entry;
               main_valid_next = 1'b1;
            end else begin
               skid_next       = in_entry;
               skid_valid_next = 1'b1;
            end
         end
         if (null_slot) begin
            main_next[INSTR_HI:INSTR_LO] = '0;
         end
      end
      occupancy_next = {1'b0, main_valid_next} + {1'b0, skid_valid_next};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_reg       <= '0;
         skid_valid_reg <= 1'b0;
      end else begin
         skid_reg       <= skid_next;
         skid_valid_reg <= skid_valid_next;
      end
   end
`else
   assign in_ready = reset & (~main_valid_reg | out_ready) & ~flush & ~null_slot;

   always_comb begin
      main_next       = main_reg;
      main_valid_next = main_valid_reg;
      if (flush) begin
         main_next       = KERNEL_ENTRY;
         main_valid_next = 1'b0;
      end else begin
         if (push) begin
            main_next       = in_entry;
            main_valid_next = 1'b1;
         end else if (pop) begin
            main_valid_next = 1'b0;
         end
         if (null_slot) begin
            main_next[INSTR_HI:INSTR_LO] = '0;
         end
      end
      occupancy_next = {1'b0, main_valid_next};
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_reg       <= DEFAULT_ENTRY;
         main_valid_reg <= 1'b0;
         occupancy_reg  <= 2'd0;
      end else begin
         main_reg       <= main_next;
         main_valid_reg <= main_valid_next;
         occupancy_reg  <= occupancy_next;
      end
   end

   assign out_valid = main_valid_reg;
   assign out_pc    = main_reg[E_W-1:PC_LO];
   assign out_instr = main_reg[INSTR_HI:INSTR_LO];
   assign out_bd    = main_reg[EXC_W];
   assign out_exc   = main_reg[EXC_W-1:0];
   assign occupancy = occupancy_reg;

endmodule
